// File: rtl/axi_reg_bank.sv
// Register bank with a valid/ready write channel and a one-deep registered read channel.
// Every committed write raises a one-cycle update pulse that carries the written address.
module axi_reg_bank #(
  parameter int unsigned aw = 4,
  parameter int unsigned w  = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wvalid,
  output logic          wready,
  input  logic [aw-1:0] waddr,
  input  logic [w-1:0]  wdata,
  input  logic          arvalid,
  output logic          arready,
  input  logic [aw-1:0] araddr,
  output logic          rvalid,
  input  logic          rready,
  output logic [w-1:0]  rdata,
  output logic          upd,
  output logic [aw-1:0] upd_addr
);

  localparam int unsigned DEPTH = 1 << aw;

  logic [w-1:0]  mem_q [DEPTH];
  logic          rvalid_q, rvalid_d;
  logic [w-1:0]  rdata_q, rdata_d;
  logic          upd_q;
  logic [aw-1:0] upd_addr_q, upd_addr_d;
  logic          wr_acc, rd_acc;

  assign wready  = !rst;
  assign arready = !rst && (!rvalid_q || rready);
  assign wr_acc  = wvalid && wready;
  assign rd_acc  = arvalid && arready;

  // A read and a write to the same word on the same edge return the new data.
  always_comb begin
    rvalid_d   = rvalid_q;
    rdata_d    = rdata_q;
    upd_addr_d = upd_addr_q;
    if (rd_acc) begin
      rvalid_d = 1'b1;
      rdata_d  = (wr_acc && (waddr == araddr)) ? wdata : mem_q[araddr];
    end else if (rvalid_q && rready) begin
      rvalid_d = 1'b0;
    end
    if (wr_acc) begin
      upd_addr_d = waddr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q      <= '{default: '0};
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      upd_q      <= 1'b0;
      upd_addr_q <= '0;
    end else begin
      if (wr_acc) begin
        mem_q[waddr] <= wdata;
      end
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      upd_q      <= wr_acc;
      upd_addr_q <= upd_addr_d;
    end
  end

  assign rvalid   = rvalid_q;
  assign rdata    = rdata_q;
  assign upd      = upd_q;
  assign upd_addr = upd_addr_q;

endmodule
